// File: rtl/wb_pkg.sv
// Shared widths and entry type for the write-back queue.
// Default parameter values and the {addr, data} entry struct.
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 16;
    localparam int WB_LANES  = 2;
    localparam int WB_WPORTS = 1;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_compact.sv
// Lane compactor: packs valid lanes oldest-first into slots 0..k-1.
// Ports: valid/addr/data/swap in; out_addr/out_data (packed slots), k out.
module wb_compact
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int LANES   = WB_LANES,
    parameter bit DROP_R0 = 1'b0,
    parameter int KW      = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]        valid,
    input  logic [LANES*ADDR_W-1:0] addr,
    input  logic [LANES*DATA_W-1:0] data,
    input  logic                    swap,
    output logic [LANES*ADDR_W-1:0] out_addr,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [KW-1:0]           k
);

    logic [LANES-1:0] keep;

    always_comb begin
        keep = '0;
        for (int i = 0; i < LANES; i++) begin
            keep[i] = valid[i];
            if (DROP_R0 && addr[i*ADDR_W +: ADDR_W] == '0)
                keep[i] = 1'b0;
        end
    end

    // Walk lanes in age order; each kept lane takes the next free slot.
    always_comb begin
        int slot;
        int lane;
        slot     = 0;
        lane     = 0;
        out_addr = '0;
        out_data = '0;
        for (int o = 0; o < LANES; o++) begin
            lane = swap ? (LANES - 1 - o) : o;
            if (keep[lane]) begin
                out_addr[slot*ADDR_W +: ADDR_W] =
                    addr[lane*ADDR_W +: ADDR_W];
                out_data[slot*DATA_W +: DATA_W] =
                    data[lane*DATA_W +: DATA_W];
                slot = slot + 1;
            end
        end
        k = KW'(slot);
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers up to LANES results/cycle, retires up to
// WPORTS/cycle in program order. Ports: clk, rst_n, in_* (enqueue group),
// in_ready, flush, wr_stall, wr_en/wr_addr/wr_data (write ports), count.
module wb_queue
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int LANES   = WB_LANES,
    parameter int WPORTS  = WB_WPORTS,
    parameter int DEPTH   = WB_DEPTH,
    parameter bit DROP_R0 = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*ADDR_W-1:0]    in_addr,
    input  logic [LANES*DATA_W-1:0]    in_data,
    input  logic                       in_swap,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic                       wr_stall,
    output logic [WPORTS-1:0]          wr_en,
    output logic [WPORTS*ADDR_W-1:0]   wr_addr,
    output logic [WPORTS*DATA_W-1:0]   wr_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(LANES + 1);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [LANES*ADDR_W-1:0] c_addr;
    logic [LANES*DATA_W-1:0] c_data;
    logic [KW-1:0]           k;

    logic          enq;
    logic [CW-1:0] n;

    wb_compact #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LANES   (LANES),
        .DROP_R0 (DROP_R0),
        .KW      (KW)
    ) u_compact (
        .valid    (in_valid),
        .addr     (in_addr),
        .data     (in_data),
        .swap     (in_swap),
        .out_addr (c_addr),
        .out_data (c_data),
        .k        (k)
    );

    // Registered count only: no path from wr_stall into in_ready.
    assign in_ready = (count <= CW'(DEPTH - LANES));
    assign enq      = in_ready && (|in_valid) && !flush;

    always_comb begin
        n       = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int j = 0; j < WPORTS; j++) begin
            wr_addr[j*ADDR_W +: ADDR_W] = mem_addr[head + PW'(j)];
            wr_data[j*DATA_W +: DATA_W] = mem_data[head + PW'(j)];
            if (!wr_stall && count > CW'(j)) begin
                wr_en[j] = 1'b1;
                n        = n + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < LANES; i++) begin
                if (KW'(i) < k) begin
                    mem_addr[tail + PW'(i)] <= c_addr[i*ADDR_W +: ADDR_W];
                    mem_data[tail + PW'(i)] <= c_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n);
            tail  <= tail + (enq ? PW'(k) : '0);
            count <= count + (enq ? CW'(k) : '0) - n;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Randomised + directed bench for wb_queue against a queue-based model.
// Runs DROP_R0=0 and DROP_R0=1 instances side by side on shared inputs.
module tb_wb_queue;
    import wb_pkg::*;

    localparam int AW = WB_ADDR_W;
    localparam int DW = WB_DATA_W;
    localparam int LN = WB_LANES;
    localparam int WP = WB_WPORTS;
    localparam int DP = WB_DEPTH;

    logic             clk;
    logic             rst_n;
    logic [LN-1:0]    in_valid;
    logic [LN*AW-1:0] in_addr;
    logic [LN*DW-1:0] in_data;
    logic             in_swap;
    logic             flush;
    logic             wr_stall;

    logic             rdy0, rdy1;
    logic [WP-1:0]    en0, en1;
    logic [WP*AW-1:0] wa0, wa1;
    logic [WP*DW-1:0] wd0, wd1;
    logic [$clog2(DP):0] cnt0, cnt1;

    int vectors;
    int miscompares;

    wb_entry_t q0[$];
    wb_entry_t q1[$];

    wb_queue #(.DROP_R0(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_addr(in_addr), .in_data(in_data), .in_swap(in_swap),
        .in_ready(rdy0), .flush(flush), .wr_stall(wr_stall),
        .wr_en(en0), .wr_addr(wa0), .wr_data(wd0), .count(cnt0)
    );

    wb_queue #(.DROP_R0(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_addr(in_addr), .in_data(in_data), .in_swap(in_swap),
        .in_ready(rdy1), .flush(flush), .wr_stall(wr_stall),
        .wr_en(en1), .wr_addr(wa1), .wr_data(wd1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_dut(input string pre, input logic en,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [31:0] c, input logic r,
                           input int sz, input wb_entry_t hd);
        logic exp_en;
        exp_en = !wr_stall && sz > 0;
        chk({pre, ".count"}, c, sz);
        chk({pre, ".in_ready"}, {31'b0, r}, {31'b0, (DP - sz) >= LN});
        chk({pre, ".wr_en"}, {31'b0, en}, {31'b0, exp_en});
        if (exp_en) begin
            chk({pre, ".wr_addr"}, {27'b0, a}, {27'b0, hd.addr});
            chk({pre, ".wr_data"}, {16'b0, d}, {16'b0, hd.data});
        end
    endtask

    // Check the current cycle against the model, then advance the model
    // across the coming rising edge.
    task automatic cyc();
        wb_entry_t g0[$];
        wb_entry_t g1[$];
        wb_entry_t e;
        wb_entry_t h0, h1;
        int lane, n0, n1;
        bit r0, r1;
        #3;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        cmp_dut("d0", en0[0], wa0[AW-1:0], wd0[DW-1:0], 32'(cnt0), rdy0,
                q0.size(), h0);
        cmp_dut("d1", en1[0], wa1[AW-1:0], wd1[DW-1:0], 32'(cnt1), rdy1,
                q1.size(), h1);
        for (int o = 0; o < LN; o++) begin
            lane = in_swap ? (LN - 1 - o) : o;
            if (in_valid[lane]) begin
                e.addr = in_addr[lane*AW +: AW];
                e.data = in_data[lane*DW +: DW];
                g0.push_back(e);
                if (e.addr != 0) g1.push_back(e);
            end
        end
        n0 = wr_stall ? 0 : (q0.size() < WP ? q0.size() : WP);
        n1 = wr_stall ? 0 : (q1.size() < WP ? q1.size() : WP);
        r0 = (DP - q0.size()) >= LN;
        r1 = (DP - q1.size()) >= LN;
        if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            repeat (n0) void'(q0.pop_front());
            repeat (n1) void'(q1.pop_front());
            if (r0) foreach (g0[i]) q0.push_back(g0[i]);
            if (r1) foreach (g1[i]) q1.push_back(g1[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic grp(input logic [LN-1:0] v, input logic sw,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        in_valid = v;
        in_swap  = sw;
        in_addr  = {a1, a0};
        in_data  = {d1, d0};
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        in_valid = '0;
        in_addr  = '0;
        in_data  = '0;
        in_swap  = 1'b0;
        flush    = 1'b0;
        wr_stall = 1'b0;
        #2;
        chk("rst.count", 32'(cnt0), 0);
        chk("rst.wr_en", 32'(en0), 0);
        chk("rst.in_ready", 32'(rdy0), 1);
        @(posedge clk);
        #1;
        cyc();
        rst_n = 1'b1;

        // In-order pair, then swapped pair.
        grp(2'b11, 1'b0, 5'd3, 16'h1111, 5'd7, 16'h2222);
        cyc();
        idle();
        chk("pair.count", 32'(cnt0), 2);
        chk("pair.first", 32'(wa0), 3);
        cyc();
        chk("pair.second", 32'(wa0), 7);
        cyc();
        cyc();
        grp(2'b11, 1'b1, 5'd3, 16'h1111, 5'd7, 16'h2222);
        cyc();
        idle();
        chk("swap.first", 32'(wa0), 7);
        chk("swap.first_d", 32'(wd0), 32'h2222);
        cyc();
        chk("swap.second", 32'(wa0), 3);
        cyc();
        cyc();

        // Full under stall; third group ignored.
        wr_stall = 1'b1;
        grp(2'b11, 1'b0, 5'd1, 16'hA001, 5'd2, 16'hA002);
        cyc();
        grp(2'b11, 1'b0, 5'd3, 16'hA003, 5'd4, 16'hA004);
        cyc();
        chk("full.count", 32'(cnt0), 4);
        chk("full.in_ready", 32'(rdy0), 0);
        grp(2'b11, 1'b0, 5'd5, 16'hA005, 5'd6, 16'hA006);
        cyc();
        idle();
        chk("full.hold", 32'(cnt0), 4);
        wr_stall = 1'b0;
        repeat (5) cyc();

        // Single valid lane, then r0 drop.
        wr_stall = 1'b1;
        grp(2'b10, 1'b0, 5'd9, 16'h0, 5'd5, 16'hABCD);
        cyc();
        idle();
        chk("one.count", 32'(cnt0), 1);
        wr_stall = 1'b0;
        cyc();
        cyc();
        wr_stall = 1'b1;
        grp(2'b11, 1'b0, 5'd0, 16'h5555, 5'd9, 16'h6666);
        cyc();
        idle();
        chk("r0.keep", 32'(cnt0), 2);
        chk("r0.drop", 32'(cnt1), 1);
        chk("r0.drop_addr", 32'(wa1), 9);
        wr_stall = 1'b0;
        repeat (3) cyc();

        // Flush with count=3 and a competing group.
        wr_stall = 1'b1;
        grp(2'b11, 1'b0, 5'd1, 16'hB001, 5'd2, 16'hB002);
        cyc();
        grp(2'b01, 1'b0, 5'd3, 16'hB003, 5'd4, 16'hB004);
        cyc();
        chk("flush.pre", 32'(cnt0), 3);
        wr_stall = 1'b0;
        grp(2'b11, 1'b0, 5'd5, 16'hB005, 5'd6, 16'hB006);
        flush = 1'b1;
        cyc();
        idle();
        chk("flush.count", 32'(cnt0), 0);
        chk("flush.wr_en", 32'(en0), 0);
        cyc();
        cyc();

        // Asynchronous reset mid-cycle.
        wr_stall = 1'b1;
        grp(2'b11, 1'b0, 5'd8, 16'hC001, 5'd9, 16'hC002);
        cyc();
        idle();
        wr_stall = 1'b0;
        chk("arst.pre", 32'(cnt0), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.count", 32'(cnt0), 0);
        chk("arst.wr_en", 32'(en0), 0);
        chk("arst.count1", 32'(cnt1), 0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            in_valid = LN'($urandom_range(0, (1 << LN) - 1));
            in_swap  = 1'($urandom_range(0, 1));
            for (int i = 0; i < LN; i++) begin
                in_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ?
                    '0 : AW'($urandom);
                in_data[i*DW +: DW] = DW'($urandom);
            end
            wr_stall = ($urandom_range(0, 9) < 3);
            flush    = ($urandom_range(0, 19) == 0);
            cyc();
        end
        idle();
        wr_stall = 1'b0;
        repeat (6) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Parametrised write-back queue between the functional units and the result register file. It accepts up to LANES results per cycle, each carrying a destination address. It keeps them in program order and retires up to WPORTS of them per cycle onto the register-file write ports. It replaces fixed two-lane address/result latching with buffering, back-pressure, a lane-order select, flush and drain stall.

## Interface
- ADDR_W, 5, destination address width
- DATA_W, 16, result width
- LANES, 2, input lanes (functional units), ≥1
- WPORTS, 1, register-file write ports, 1..LANES
- DEPTH, 4, queue entries; power of two, ≥LANES
- DROP_R0, 0, when 1, results addressed to register 0 are discarded at enqueue
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  LANES  per-lane result valid
- in_addr  in  LANES*ADDR_W  packed destinations; lane i at [i*ADDR_W +: ADDR_W]
- in_data  in  LANES*DATA_W  packed results; lane i at [i*DATA_W +: DATA_W]
- in_swap  in  1  0: lane 0 is oldest; 1: lane LANES-1 is oldest (reversed order)
- in_ready  out  1  queue can take a full group this cycle
- flush  in  1  synchronous clear of all entries
- wr_stall  in  1  register file cannot accept writes this cycle
- wr_en  out  WPORTS  per-port write enable
- wr_addr  out  WPORTS*ADDR_W  packed write addresses, port 0 is oldest
- wr_data  out  WPORTS*DATA_W  packed write data
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: circular buffer of DEPTH {addr, data} entries, head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- in_ready = (DEPTH − count) ≥ LANES. It uses the registered count and ignores any same-cycle dequeue. It is conservative and has no combinational path from wr_stall.
- Enqueue when in_ready and at least one in_valid bit is set. Group acceptance is all-or-nothing. When in_ready=0, in_valid is ignored, and the producer holds its outputs.
- Compaction: the valid lanes are written to consecutive slots from the tail, oldest first, in the order selected by in_swap. Invalid lanes consume no slot. With DROP_R0=1, a lane with addr==0 counts as invalid. The tail advances by the number of kept lanes, k.
- Dequeue: n = 0 if wr_stall, else min(count, WPORTS). Port j presents entry head+j. wr_en[j] = (j < n). Head advances by n.
- Next count = count + k − n. Enqueue and dequeue in the same cycle are both honoured.
- Ordering: same-address entries retire in enqueue order. When two entries to one address retire on different ports in the same cycle, the higher port is younger, and the register file must give it priority.
- flush: head, tail and count go to 0 at the next edge. A flush takes priority over any enqueue in the same cycle. wr_en is still driven normally during the flush cycle.
- wr_addr and wr_data for ports with wr_en=0 are don't-care. In practice they show stale slot contents.

## Timing
- Reset (rst_n=0, immediate): head=tail=count=0, wr_en=0, in_ready=1. Storage contents are not reset.
- Latency: a result accepted at edge t can first appear on wr_* in the cycle after edge t. There is no bypass from in_* to wr_*.
- wr_en, wr_addr and wr_data are combinational from the registered head and count, gated by wr_stall.
- Full: with count=DEPTH, in_ready=0. With DEPTH−count < LANES, in_ready=0 even when only one lane is valid.
- Empty: with count=0, wr_en=0 regardless of wr_stall.
- Wrap: a group that straddles slot DEPTH−1 continues at slot 0.
- rst_n deasserting mid-burst: the queue restarts empty, and no stale write is issued.

## Structure
- Shared package wb_pkg holds localparams for the default widths, plus an entry struct {addr, data} sized by the package widths.
- Sub-module wb_compact: a combinational LANES-to-LANES compactor that also applies the order select. Inputs are valid, addr, data and swap. Outputs are the packed compacted entries and the count k.
- The top level holds the storage array, the pointers and count, and the dequeue logic.

## Test plan
- After reset, drive lane0 {addr 3, data 0x1111} and lane1 {addr 7, data 0x2222}, in_swap=0. The next cycle shows wr_en=1, addr 3, data 0x1111. The cycle after shows addr 7, data 0x2222. count goes 2, 1, 0.
- Same pair with in_swap=1: addr 7 / 0x2222 retires first, then addr 3 / 0x1111.
- Hold wr_stall=1 and send two full groups (DEPTH=4). count reaches 4 and in_ready=0. A third group is ignored, and count stays 4. Release the stall: four writes retire in enqueue order.
- Lane0 invalid, lane1 {addr 5, data 0xABCD}: exactly one entry is kept (count=1). With DROP_R0=1, {addr 0} on lane0 is discarded, and only lane1 is kept.
- Assert flush with count=3 and a valid group in the same cycle: count=0 at the next edge, and no write occurs afterwards.
- Assert rst_n low mid-cycle with count=2: wr_en=0 and count=0 immediately, without waiting for a clock edge.
